uart_tx_ctrl: RTL and testbench

Frame controller for the UART transmitter. It accepts a byte from the upstream parallel interface and sequences the external `serializer` (`ser_en`/`ser_done`/`ser_data`). It generates start, optional parity and stop bits, and drives the TX line through an internal output mux. It sits between the data source and the `serializer`, and owns the serial line.

---
 rtl/uart_tx_ctrl_if.sv | 27 ++
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Upstream byte handshake plus serializer control bundle for the UART frame controller.
// No storage; pure signal grouping.
// master = byte source and serializer side, slave = frame controller side.
interface uart_tx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] P_DATA;
    logic              Data_Valid;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              busy;
    logic              ser_load;
    logic [DATA_W-1:0] ser_pdata;
    logic              ser_en;
    logic              ser_done;
    logic              ser_data;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        input  busy, ser_load, ser_pdata, ser_en
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        output busy, ser_load, ser_pdata, ser_en
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART frame controller: start bit, serializer-driven data bits, optional parity, stop bit.
// Start bit on TX_OUT the cycle after accept; frame is DATA_W+2 (+1 with parity) cycles.
// Data_Valid is only taken in IDLE or STOP; busy tells the source to hold otherwise.
module uart_tx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    uart_tx_ctrl_if.slave     bus,
    output logic              TX_OUT,
    output logic              ctrl_err
);
    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  pdata_q, pdata_d;
    logic               par_en_q, par_en_d;
    logic               par_bit_q, par_bit_d;

    logic               accept;
    logic               last_cnt;
    logic               busy_c;
    logic               ser_load_c;
    logic               ser_en_c;

    // STOP doubles as an accept slot so back-to-back frames have no idle gap.
    assign accept   = bus.Data_Valid && ((state_q == IDLE) || (state_q == STOP));
    assign last_cnt = (cnt_q == LAST_BIT);

    // State register; reset forces IDLE, which drives the line high immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DATA exits on whichever of ser_done or the local count arrives first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = DATA;
            DATA:    if (bus.ser_done || last_cnt) state_d = par_en_q ? PARITY : STOP;
            PARITY:  state_d = STOP;
            STOP:    state_d = accept ? START : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame-scoped data: byte, parity settings and bit counter, frozen between accepts.
    always_comb begin
        pdata_d   = pdata_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        cnt_d     = cnt_q;
        if (accept) begin
            pdata_d   = bus.P_DATA;
            par_en_d  = bus.PAR_EN;
            par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
        end
        if (state_q == START) begin
            cnt_d = '0;
        end else if (state_q == DATA) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Frame-scoped registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pdata_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pdata_q   <= pdata_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            cnt_q     <= cnt_d;
        end
    end

    // Output decode from registered state only; Data_Valid never reaches TX_OUT.
    always_comb begin
        TX_OUT     = 1'b1;
        busy_c     = 1'b0;
        ser_load_c = 1'b0;
        ser_en_c   = 1'b0;
        ctrl_err   = 1'b0;
        case (state_q)
            START: begin
                TX_OUT     = 1'b0;
                ser_load_c = 1'b1;
                busy_c     = 1'b1;
            end
            DATA: begin
                TX_OUT   = bus.ser_data;
                ser_en_c = 1'b1;
                busy_c   = 1'b1;
                // Serializer and local count must agree on the last bit.
                ctrl_err = bus.ser_done ^ last_cnt;
            end
            PARITY: begin
                TX_OUT = par_bit_q;
                busy_c = 1'b1;
            end
            default: begin
                TX_OUT = 1'b1;
            end
        endcase
    end

    assign bus.busy      = busy_c;
    assign bus.ser_load  = ser_load_c;
    assign bus.ser_en    = ser_en_c;
    assign bus.ser_pdata = pdata_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
    localparam int DATA_W = 8;

    typedef struct {
        logic [10:0] bits;
        int          len;
        int          ndata;
        int          nerr;
        bit          b2b;
    } frame_t;

    logic CLK = 1'b0;
    logic RST;
    logic TX_OUT;
    logic ctrl_err;

    uart_tx_ctrl_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_ctrl #(.DATA_W(DATA_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .TX_OUT   (TX_OUT),
        .ctrl_err (ctrl_err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ---------------- serializer model ----------------
    logic [DATA_W-1:0] sh_q;
    logic [3:0]        sidx_q;
    int                fault_idx = -1;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_q   <= '0;
            sidx_q <= '0;
        end else if (bus.ser_load) begin
            sh_q   <= bus.ser_pdata;
            sidx_q <= '0;
        end else if (bus.ser_en) begin
            sidx_q <= sidx_q + 4'd1;
        end
    end

    assign bus.ser_data = sh_q[sidx_q[2:0]];
    assign bus.ser_done = bus.ser_en && ((sidx_q == 4'd7) || (int'(sidx_q) == fault_idx));

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame: start, LSB-first data (truncated if the serializer ends early),
    // optional parity over the full byte, stop.
    function automatic frame_t model(input logic [7:0] d, input logic pe, input logic pt,
                                     input int fault, input bit b2b);
        frame_t f;
        int nd;
        int p;
        nd     = (fault >= 0) ? fault + 1 : DATA_W;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) f.bits[1+i] = d[i];
        p = 1 + nd;
        if (pe) begin
            f.bits[p] = (^d) ^ pt;
            p++;
        end
        f.bits[p] = 1'b1;
        f.len     = p + 1;
        f.ndata   = nd;
        f.nerr    = (fault >= 0 && fault < DATA_W - 1) ? 1 : 0;
        f.b2b     = b2b;
        return f;
    endfunction

    frame_t exp_q[$];

    // ---------------- monitor ----------------
    frame_t      cur;
    bit          in_frame = 0;
    bit          prev_end = 0;
    bit          ended;
    int          pos;
    int          n_busy, n_en, n_load, n_err;
    logic [10:0] got_bits;

    initial forever begin
        @(negedge CLK);
        ended = 0;
        if (!RST) begin
            exp_q.delete();
            in_frame = 0;
        end else begin
            if (!in_frame && TX_OUT === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start actual=frame required=idle");
                end else begin
                    cur      = exp_q.pop_front();
                    in_frame = 1;
                    pos      = 0;
                    n_busy   = 0;
                    n_en     = 0;
                    n_load   = 0;
                    n_err    = 0;
                    got_bits = '0;
                    if (cur.b2b) chk("b2b_no_gap", 32'(prev_end), 32'd1);
                end
            end
            if (in_frame) begin
                got_bits[pos] = TX_OUT;
                n_busy += int'(bus.busy);
                n_en   += int'(bus.ser_en);
                n_load += int'(bus.ser_load);
                n_err  += int'(ctrl_err);
                pos++;
                if (pos == cur.len) begin
                    chk("frame_bits", 32'(got_bits), 32'(cur.bits));
                    chk("busy_cycles", n_busy, cur.len - 1);
                    chk("ser_en_cycles", n_en, cur.ndata);
                    chk("ser_load_pulses", n_load, 1);
                    chk("ctrl_err_pulses", n_err, cur.nerr);
                    in_frame = 0;
                    ended    = 1;
                end
            end
        end
        prev_end = ended;
    end

    // ---------------- stimulus ----------------
    // Called #1 after an edge in a cycle where the DUT is in IDLE or STOP; returns
    // #1 into the STOP cycle of the issued frame.
    task automatic issue(input logic [7:0] d, input logic pe, input logic pt,
                         input int fault, input bit b2b, input bit noise);
        frame_t f;
        f = model(d, pe, pt, fault, b2b);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        fault_idx      = fault;
        exp_q.push_back(f);
        @(posedge CLK); #1;
        for (int c = 0; c < f.len - 1; c++) begin
            if (noise) begin
                bus.P_DATA     = 8'($urandom);
                bus.PAR_EN     = 1'($urandom);
                bus.PAR_TYP    = 1'($urandom);
                bus.Data_Valid = 1'($urandom);
            end else begin
                bus.Data_Valid = 1'b0;
            end
            @(posedge CLK); #1;
        end
        bus.Data_Valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.Data_Valid = 1'b0;
        fault_idx      = -1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic mid_frame_reset();
        bus.P_DATA     = 8'hC6;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b1;
        exp_q.push_back(model(8'hC6, 1'b0, 1'b0, -1, 1'b0));
        @(posedge CLK); #1;
        bus.Data_Valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk("midrst_tx_out", 32'(TX_OUT), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_ser_en", 32'(bus.ser_en), 32'd0);
        @(posedge CLK); #1;
        chk("midrst_tx_hold", 32'(TX_OUT), 32'd1);
        chk("midrst_flush", exp_q.size(), 32'd0);
        RST = 1'b1;
        idle(2);
    endtask

    initial begin
        bit b2b_next;
        RST            = 1'b0;
        bus.Data_Valid = 1'b1;
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = 1'b1;
        bus.PAR_TYP    = 1'b1;
        #2;
        chk("rst_tx_out", 32'(TX_OUT), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ser_en", 32'(bus.ser_en), 32'd0);
        chk("rst_ser_load", 32'(bus.ser_load), 32'd0);
        chk("rst_ctrl_err", 32'(ctrl_err), 32'd0);
        chk("rst_ser_pdata", 32'(bus.ser_pdata), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_hold_tx_out", 32'(TX_OUT), 32'd1);
        chk("rst_hold_busy", 32'(bus.busy), 32'd0);
        bus.Data_Valid = 1'b0;
        RST = 1'b1;
        idle(2);

        issue(8'hB3, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        idle(2);
        issue(8'hA5, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        idle(2);
        issue(8'hA5, 1'b1, 1'b1, -1, 1'b0, 1'b1);
        idle(2);
        issue(8'h01, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        issue(8'hFF, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        idle(2);
        issue(8'h5C, 1'b1, 1'b0, 4, 1'b0, 1'b0);
        idle(2);
        mid_frame_reset();
        issue(8'h3E, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        idle(2);

        b2b_next = 0;
        for (int n = 0; n < 40; n++) begin
            int flt;
            flt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            issue(8'($urandom), 1'($urandom), 1'($urandom), flt, b2b_next, 1'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                b2b_next = 1;
            end else begin
                b2b_next = 0;
                idle(int'($urandom_range(1, 3)));
            end
        end
        idle(1);

        for (int i = 0; i < 200 && (exp_q.size() != 0 || in_frame); i++) @(posedge CLK);
        #1;
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_in_frame", 32'(in_frame), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
